// File: rtl/avg_pkg.sv
// Shared types and constants for the closest-to-average filter and its output buffer.
package avg_pkg;
  localparam int AVG_DW            = 16;
  localparam int AVG_BUF_DEPTH_DEF = 8;

  typedef logic [AVG_DW-1:0] avg_sample_t;
endpackage

// File: rtl/avg_buf_ram.sv
// DEPTH x DW storage for avg_buf: one synchronous write port, one asynchronous read port.
module avg_buf_ram
  import avg_pkg::*;
#(
  parameter int DW    = AVG_DW,
  parameter int DEPTH = AVG_BUF_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // No reset: contents are hidden by the empty gating on dout.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/avg_buf.sv
// Show-ahead output FIFO behind the averaging filter; drops and flags words when full.
// Optional: define AVG_BUF_DROP_CNT_EN to build the 16-bit saturating drop counter.
module avg_buf
  import avg_pkg::*;
#(
  parameter int DW    = AVG_DW,
  parameter int DEPTH = AVG_BUF_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DW-1:0]             din,
  input  logic                      din_vld,
  output logic [DW-1:0]             dout,
  output logic                      dout_vld,
  input  logic                      dout_rdy,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      overflow,
  input  logic                      ovf_clr,
  output logic [15:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic [DW-1:0] rdata;
  logic          pop, push, drop;

  assign full     = (cnt_q == DEPTH_C);
  assign dout_vld = (cnt_q != '0);
  assign count    = cnt_q;
  assign overflow = ovf_q;

  assign pop  = dout_vld & dout_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = din_vld & (~full | pop);
  assign drop = din_vld & full & ~pop;

  assign dout = dout_vld ? rdata : '0;

  avg_buf_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

`ifdef AVG_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != '1)    drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_avg_buf.sv
// Directed bench for avg_buf with a queue scoreboard and per-cycle reference model.
module tb_avg_buf;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   din;
  logic            din_vld;
  logic [DW-1:0]   dout;
  logic            dout_vld;
  logic            dout_rdy;
  logic [AW:0]     count;
  logic            full;
  logic            overflow;
  logic            ovf_clr;
  logic [15:0]     drop_cnt;

  int              vectors = 0;
  int              fails   = 0;
  logic [DW-1:0]   sb[$];
  logic            m_ovf;
  logic [15:0]     m_dcnt;

  avg_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check current outputs against the model, advance the model, then cross one edge.
  task automatic tick();
    int   n;
    logic m_pop, m_full, m_drop;
    logic [DW-1:0] exp;
    n      = sb.size();
    m_full = (n == DEPTH);
    m_pop  = (n != 0) && dout_rdy;
    m_drop = din_vld && m_full && !m_pop;
    chk("count",    32'(count),    32'(n));
    chk("full",     32'(full),     32'(m_full));
    chk("dout_vld", 32'(dout_vld), 32'(n != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
    if (n == 0) chk("dout_empty", 32'(dout), 32'd0);
    if (m_pop) begin
      exp = sb.pop_front();
      chk("pop_data", 32'(dout), 32'(exp));
    end
    if (din_vld && (!m_full || m_pop)) sb.push_back(din);
    if (m_drop) begin
      m_ovf = 1'b1;
`ifdef AVG_BUF_DROP_CNT_EN
      if (m_dcnt != 16'hFFFF) m_dcnt = m_dcnt + 16'd1;
`endif
    end else if (ovf_clr) m_ovf = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; din = '0; din_vld = 1'b0; dout_rdy = 1'b0; ovf_clr = 1'b0;
    m_ovf = 1'b0; m_dcnt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout_vld", 32'(dout_vld), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Fill three then drain
    din_vld = 1'b1;
    din = 16'h0010; tick();
    din = 16'h0020; tick();
    din = 16'h0030; tick();
    din_vld = 1'b0;
    chk("fill_count", 32'(count), 32'd3);
    chk("fill_head", 32'(dout), 32'h0010);
    tick();
    dout_rdy = 1'b1;
    repeat (3) tick();
    dout_rdy = 1'b0;
    tick();

    // Overflow: eight words then one dropped
    din_vld = 1'b1;
    for (int i = 1; i <= 8; i++) begin din = 16'(i); tick(); end
    din = 16'hBEEF; tick();
    din_vld = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    tick();
    dout_rdy = 1'b1;
    repeat (8) tick();
    dout_rdy = 1'b0;

    // ovf_clr alone clears the flag, leaves drop_cnt
    ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    tick();

    // Full with simultaneous push and pop
    din_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin din = 16'h0100 + 16'(i); tick(); end
    din = 16'h1234; dout_rdy = 1'b1; tick();
    din_vld = 1'b0;
    chk("pp_count", 32'(count), 32'd8);
    chk("pp_no_ovf", 32'(overflow), 32'd0);
    repeat (9) tick();
    dout_rdy = 1'b0;
    tick();

    // Drop and ovf_clr in the same cycle: set wins
    din_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin din = 16'h0A00 + 16'(i); tick(); end
    din = 16'hDEAD; ovf_clr = 1'b1; tick();
    din_vld = 1'b0; ovf_clr = 1'b0;
    chk("set_wins", 32'(overflow), 32'd1);
    dout_rdy = 1'b1;
    repeat (9) tick();

    // Wrap-around streaming, one cycle latency
    din_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin din = 16'(i); tick(); end
    din_vld = 1'b0;
    repeat (2) tick();
    dout_rdy = 1'b0;

    // Asynchronous reset between edges
    din_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin din = 16'h0500 + 16'(i); tick(); end
    din_vld = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd5);
    #3 reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_dout_vld", 32'(dout_vld), 32'd0);
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    sb.delete(); m_ovf = 1'b0; m_dcnt = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    din_vld = 1'b1; din = 16'h7777; tick();
    din_vld = 1'b0;
    chk("post_rst_head", 32'(dout), 32'h7777);
    dout_rdy = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/avg_buf.md
# avg_buf

Output buffer sitting directly downstream of the 12-sample closest-to-average filter. Each cycle the filter's ready flag is high, the block captures the filter's 16-bit result into a parameterised FIFO. It presents the words to the consumer over a valid/ready handshake. The filter cannot be back-pressured, so words arriving while the buffer is full are dropped and flagged.

## Interface
- DW, 16, sample width; matches filter output width.
- DEPTH, 8, FIFO depth in words; power of two, ≥ 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- din  in  DW  filter result word.
- din_vld  in  1  connected to filter ready; word on din is valid this cycle.
- dout  out  DW  head-of-FIFO word; 0 when empty.
- dout_vld  out  1  FIFO non-empty.
- dout_rdy  in  1  consumer accepts dout this cycle.
- count  out  AW+1  words currently stored, 0..DEPTH.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; a word was dropped.
- ovf_clr  in  1  synchronous clear of overflow.
- drop_cnt  out  16  saturating count of dropped words.

## Operation
- Pop: dout_vld & dout_rdy.
- Push: din_vld & (!full | pop).
  - Full with simultaneous pop accepts the write. Count is unchanged and no drop occurs.
- Drop: din_vld & full & !pop. The word is discarded and pointers are unchanged.
- Storage is show-ahead: dout is read combinationally at rd_ptr and gated to 0 while empty.
- There is no write-to-read bypass. A word written into an empty FIFO appears on dout the following cycle.
- Pointers are AW bits and wrap modulo DEPTH. Full/empty are derived from the count register, not from pointer comparison.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- dout_rdy while empty is ignored; count never underflows.
- overflow:
  - Set on any drop.
  - Cleared by ovf_clr.
  - If a drop and ovf_clr occur in the same cycle, set wins.
- drop_cnt increments per drop and saturates at 0xFFFF. It is not cleared by ovf_clr.
- Word order is strictly preserved. Dropped words leave no gap marker.

## Timing
- Reset values, effective immediately on reset assertion:
  - count = 0, full = 0, overflow = 0, drop_cnt = 0.
  - dout_vld = 0, dout = 0.
  - Pointers are 0.
- Memory contents are not reset; they are invisible because dout is gated.
- Reset asserted mid-stream: all in-flight words are lost. Outputs take reset values immediately, without waiting for a clock edge.
- Latency from din_vld to dout_vld: 1 cycle when empty.
- Sustained throughput: 1 word/cycle in and out.
- The filter asserts din_vld continuously once started. With dout_rdy held high, count stays ≤ 1.
- count, full, overflow and drop_cnt are registered and update on the edge after the causing event. dout_vld = (count != 0).

## Configuration
- AVG_BUF_DROP_CNT_EN defined: the 16-bit saturating drop counter is built and drives drop_cnt.
- AVG_BUF_DROP_CNT_EN not defined: no counter flops are built and drop_cnt is tied to 16'd0. The overflow flag behaves identically in both builds.

## Structure
- Shared package avg_pkg holds:
  - constant AVG_DW = 16;
  - constant AVG_BUF_DEPTH_DEF = 8;
  - typedef avg_sample_t (logic [AVG_DW-1:0]), used by the filter and this block.
- One sub-module, avg_buf_ram:
  - DEPTH×DW register array with one synchronous write port (we, waddr, wdata);
  - one asynchronous read port (raddr, rdata);
  - no reset on the array.
- Pointer, count, flag and counter logic live in avg_buf itself.

## Test plan
- Fill and drain: reset, then push 0x0010, 0x0020, 0x0030 with dout_rdy=0. Expect count=3, dout_vld=1, dout=0x0010. Then dout_rdy=1 for 3 cycles. Expect 0x0010/0x0020/0x0030 in order, then count=0, dout_vld=0, dout=0.
- Overflow: DEPTH=8, dout_rdy=0, push 0x0001..0x0008, then 0xBEEF. Expect full=1 and count=8 with 0xBEEF absent. Expect overflow=1 and drop_cnt=1 on the next edge. Drain yields 0x0001..0x0008.
- Full with simultaneous push+pop: at count=8, push 0x1234 with dout_rdy=1. Expect count stays 8, overflow stays 0, and 0x1234 emerges last after draining.
- Wrap-around: continuous din_vld with incrementing data 0..19 and dout_rdy=1. Expect dout sequence 0..19 one cycle delayed, count ≤ 1, no drops.
- Flag clear priority:
  - ovf_clr and a drop in the same cycle: overflow stays 1.
  - ovf_clr alone: overflow=0, drop_cnt unchanged.
  - With the macro undefined: drop_cnt stays 0 throughout.
- Async reset: assert reset between edges with count=5. Expect count=0, dout_vld=0, dout=0 before the next edge. After release, the first push appears on dout after 1 cycle.
